// File: rtl/ahblite_gpio_seq_if.sv
// ahblite_gpio_seq_if: AHB-Lite slave port bundle for the GPIO sequencer
interface ahblite_gpio_seq_if;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [3:0]  HPROT;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic        HRESP;
  modport master (output HSEL, HADDR, HTRANS, HSIZE, HPROT, HWRITE, HWDATA, HREADY,
                  input HREADYOUT, HRDATA, HRESP);
  modport slave  (input HSEL, HADDR, HTRANS, HSIZE, HPROT, HWRITE, HWDATA, HREADY,
                  output HREADYOUT, HRDATA, HRESP);
endinterface

// File: rtl/ahblite_gpio_seq.sv
// ahblite_gpio_seq: AHB-Lite slave that plays a {data, hold} pattern table onto GPIO outputs
module ahblite_gpio_seq #(
  parameter int DEPTH  = 8,
  parameter int HOLD_W = 16
) (
  input  logic                HCLK,
  input  logic                HRESETn,
  ahblite_gpio_seq_if.slave   bus,
  output logic                outEn,
  output logic [7:0]          oData,
  input  logic [7:0]          iData,
  output logic                irq
);
  localparam int AW = $clog2(DEPTH);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state, state_d;
  logic [5:0] addr_q;
  logic wr_q, rd_q;
  logic loop, oen_idle, irq_en, done;
  logic [3:0] len, len_q;
  logic [2:0] idx, next_idx;
  logic [HOLD_W-1:0] cnt;
  logic [7:0] pat_data [DEPTH];
  logic [HOLD_W-1:0] pat_hold [DEPTH];
  logic [3:0] a, pa;
  logic [AW-1:0] pi, ld;
  logic pat_hit, wr_ctrl, start, stop, go, last, finish, load, done_set, done_clr, unused_ok;
  assign a        = addr_q[5:2];
  assign pa       = a - 4'd4;
  assign pi       = pa[AW-1:0];
  assign pat_hit  = (|a[3:2]) && (pa < 4'(DEPTH));
  assign wr_ctrl  = wr_q && a == 4'd0;
  assign stop     = wr_ctrl && bus.HWDATA[1];
  assign start    = wr_ctrl && bus.HWDATA[0] && !bus.HWDATA[1];
  assign go       = state == IDLE && start && len != 4'd0;
  assign last     = {1'b0, idx} == len_q - 4'd1;
  // a step ends when its hold counter has run out, unless a STOP lands on the same edge
  assign finish   = state == RUN && !stop && cnt == '0 && last && !loop;
  assign load     = go || (state == RUN && !stop && cnt == '0 && (!last || loop));
  assign next_idx = (go || last) ? 3'd0 : idx + 3'd1;
  assign ld       = next_idx[AW-1:0];
  assign done_set = finish || (state == IDLE && start && len == 4'd0);
  assign done_clr = wr_q && a == 4'd1 && bus.HWDATA[1];
  assign outEn    = state == RUN ? 1'b1 : oen_idle;
  assign bus.HREADYOUT = 1'b1;
  assign bus.HRESP     = 1'b0;
  assign bus.HRDATA = !rd_q       ? 32'd0 :
                      a == 4'd0   ? {27'd0, irq_en, oen_idle, loop, 2'b00} :
                      a == 4'd1   ? {25'd0, idx, 2'b00, done, state == RUN} :
                      a == 4'd2   ? {28'd0, len} :
                      a == 4'd3   ? {24'd0, iData} :
                      pat_hit     ? 32'({pat_hold[pi], pat_data[pi]}) : 32'd0;
  assign unused_ok = ^{bus.HSIZE, bus.HPROT, bus.HADDR[31:6], bus.HTRANS[0],
                       bus.HWDATA[31:8+HOLD_W], addr_q[1:0], pa};
  always_comb begin
    state_d = state;
    state_d = state == IDLE ? (go ? RUN : IDLE) : ((stop || finish) ? IDLE : RUN);
  end
  always_ff @(posedge HCLK or negedge HRESETn)
    if (!HRESETn) begin
      state    <= IDLE;
      addr_q   <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      loop     <= 1'b0;
      oen_idle <= 1'b0;
      irq_en   <= 1'b0;
      done     <= 1'b0;
      len      <= '0;
      len_q    <= '0;
      idx      <= '0;
      cnt      <= '0;
      oData    <= '0;
      irq      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        pat_data[i] <= '0;
        pat_hold[i] <= '0;
      end
    end else begin
      state <= state_d;
      wr_q  <= bus.HSEL && bus.HTRANS[1] && bus.HREADY && bus.HWRITE;
      rd_q  <= bus.HSEL && bus.HTRANS[1] && bus.HREADY && !bus.HWRITE;
      if (bus.HSEL && bus.HTRANS[1] && bus.HREADY) addr_q <= bus.HADDR[5:0];
      if (wr_ctrl) {irq_en, oen_idle, loop} <= bus.HWDATA[4:2];
      if (wr_q && a == 4'd2) len <= (bus.HWDATA[3:0] > 4'(DEPTH)) ? 4'(DEPTH) : bus.HWDATA[3:0];
      if (wr_q && pat_hit) begin
        pat_data[pi] <= bus.HWDATA[7:0];
        pat_hold[pi] <= bus.HWDATA[8 +: HOLD_W];
      end
      done <= done_set || (done && !done_clr);
      irq  <= done && irq_en;
      if (go) len_q <= len;
      if (load) begin
        idx   <= next_idx;
        oData <= pat_data[ld];
        cnt   <= pat_hold[ld];
      end else if (state == RUN && !stop && cnt != '0) cnt <= cnt - HOLD_W'(1);
    end
endmodule

// File: tb/tb_ahblite_gpio_seq.sv
// tb_ahblite_gpio_seq: directed self-checking bench for the AHB-Lite GPIO sequencer
module tb_ahblite_gpio_seq;
  logic HCLK = 1'b0, HRESETn = 1'b0;
  logic outEn, irq;
  logic [7:0] oData, iData;
  logic [31:0] d;
  int pass_cnt = 0, total = 0;
  ahblite_gpio_seq_if bus();
  ahblite_gpio_seq dut (.HCLK(HCLK), .HRESETn(HRESETn), .bus(bus), .outEn(outEn),
                        .oData(oData), .iData(iData), .irq(irq));
  always #5 HCLK = ~HCLK;
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask
  task automatic wr(input logic [31:0] addr, input logic [31:0] data);
    @(negedge HCLK);
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b1; bus.HADDR = addr;
    @(negedge HCLK);
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00; bus.HWRITE = 1'b0; bus.HWDATA = data;
  endtask
  task automatic rd(input logic [31:0] addr, output logic [31:0] data);
    @(negedge HCLK);
    bus.HSEL = 1'b1; bus.HTRANS = 2'b10; bus.HWRITE = 1'b0; bus.HADDR = addr;
    @(negedge HCLK);
    bus.HSEL = 1'b0; bus.HTRANS = 2'b00;
    data = bus.HRDATA;
  endtask
  task automatic step(input string tag, input logic [7:0] exp_d);
    @(negedge HCLK);
    chk(tag, {24'd0, oData}, {24'd0, exp_d});
    chk({tag, "_oen"}, {31'd0, outEn}, 32'd1);
  endtask
  initial begin
    bus.HSEL = 1'b0; bus.HADDR = '0; bus.HTRANS = 2'b00; bus.HSIZE = 3'b010; bus.HPROT = 4'h3;
    bus.HWRITE = 1'b0; bus.HWDATA = '0; bus.HREADY = 1'b1; iData = 8'hA5;
    repeat (3) @(negedge HCLK);
    HRESETn = 1'b1;
    chk("rst_odata", {24'd0, oData}, 32'd0);
    chk("rst_outen", {31'd0, outEn}, 32'd0);
    chk("rst_irq", {31'd0, irq}, 32'd0);
    for (int i = 0; i < 12; i++) begin
      rd(32'(i * 4), d);
      chk($sformatf("rst_rd_%0h", i * 4), d, i == 3 ? 32'hA5 : 32'd0);
    end
    // three-step one-shot sequence
    wr(32'h10, 32'h211); wr(32'h14, 32'h022); wr(32'h18, 32'h133); wr(32'h08, 32'd3);
    rd(32'h10, d); chk("pat0_rb", d, 32'h211);
    wr(32'h00, 32'h01);
    step("seq_s0a", 8'h11); step("seq_s0b", 8'h11); step("seq_s0c", 8'h11);
    step("seq_s1", 8'h22); step("seq_s2a", 8'h33); step("seq_s2b", 8'h33);
    @(negedge HCLK);
    chk("seq_end_oen", {31'd0, outEn}, 32'd0);
    chk("seq_end_data", {24'd0, oData}, 32'h33);
    rd(32'h04, d); chk("seq_status", d, 32'h22);
    wr(32'h04, 32'h2);
    rd(32'h04, d); chk("done_w1c", d, 32'h20);
    wr(32'h08, 32'd15);
    rd(32'h08, d); chk("len_clamp", d, 32'd8);
    // looping two-step pattern, then STOP
    wr(32'h10, 32'h044); wr(32'h14, 32'h155); wr(32'h08, 32'd2);
    wr(32'h00, 32'h05);
    for (int k = 0; k < 9; k++) step($sformatf("loop_%0d", k), (k % 3 == 0) ? 8'h44 : 8'h55);
    wr(32'h00, 32'h02);
    @(negedge HCLK);
    chk("stop_oen", {31'd0, outEn}, 32'd0);
    chk("stop_data", {24'd0, oData}, 32'h55);
    rd(32'h04, d); chk("stop_busy_done", d & 32'h3, 32'd0);
    // LEN=0 start: immediate DONE and interrupt
    wr(32'h08, 32'd0);
    wr(32'h00, 32'h11);
    rd(32'h04, d); chk("len0_status", d, 32'h12);
    chk("len0_data", {24'd0, oData}, 32'h55);
    chk("len0_irq", {31'd0, irq}, 32'd1);
    wr(32'h04, 32'h2);
    @(negedge HCLK); chk("irq_lag", {31'd0, irq}, 32'd1);
    @(negedge HCLK); chk("irq_clr", {31'd0, irq}, 32'd0);
    // second START during RUN is ignored
    wr(32'h10, 32'h211); wr(32'h14, 32'h022); wr(32'h08, 32'd3);
    wr(32'h00, 32'h01);
    step("dbl_s0", 8'h11);
    wr(32'h00, 32'h01);
    step("dbl_s1", 8'h22); step("dbl_s2a", 8'h33); step("dbl_s2b", 8'h33);
    @(negedge HCLK);
    chk("dbl_end_oen", {31'd0, outEn}, 32'd0);
    // START|STOP stops the run
    wr(32'h00, 32'h01);
    step("ss_s0", 8'h11);
    wr(32'h00, 32'h03);
    @(negedge HCLK);
    chk("ss_oen", {31'd0, outEn}, 32'd0);
    chk("ss_data", {24'd0, oData}, 32'h11);
    rd(32'h04, d); chk("ss_busy", d & 32'h1, 32'd0);
    // PAT1 rewritten during step 0
    wr(32'h00, 32'h01);
    wr(32'h14, 32'h066);
    step("patw_s0", 8'h11); step("patw_s1", 8'h66); step("patw_s2", 8'h33);
    // asynchronous reset mid-run
    wr(32'h00, 32'h01);
    step("arst_pre", 8'h11);
    #2 HRESETn = 1'b0;
    #1;
    chk("arst_data", {24'd0, oData}, 32'd0);
    chk("arst_oen", {31'd0, outEn}, 32'd0);
    chk("arst_irq", {31'd0, irq}, 32'd0);
    @(negedge HCLK) HRESETn = 1'b1;
    rd(32'h04, d); chk("arst_status", d, 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end
endmodule

// File: doc/ahblite_gpio_seq.md
Name: ahblite_gpio_seq

Overview:
AHB-Lite slave that sequences the GPIO output pins through a programmable pattern table without CPU involvement. Software loads up to DEPTH {data, hold} steps, sets a length and writes START. The block then drives oData/outEn step by step, each for a programmed number of HCLK cycles, optionally looping. It sits on the same AHB-Lite matrix as the other peripherals, in place of direct GPIO register writes, and raises a level interrupt on completion.

Parameters:
DEPTH, 8, number of pattern entries (power of two, 2..8).
HOLD_W, 16, width of the per-step hold counter.

Ports:
HCLK  input  1  system clock
HRESETn  input  1  asynchronous active-low reset
HSEL  input  1  slave select
HADDR  input  32  address; HADDR[5:0] decoded
HTRANS  input  2  transfer type; HTRANS[1]=1 means valid
HSIZE  input  3  ignored (word access only)
HPROT  input  4  ignored
HWRITE  input  1  write/read
HWDATA  input  32  write data (data phase)
HREADY  input  1  bus ready
HREADYOUT  output  1  tied 1
HRDATA  output  32  read data (data phase)
HRESP  output  1  tied 0
outEn  output  1  GPIO output enable
oData  output  8  GPIO output data
iData  input  8  GPIO input pins
irq  output  1  completion interrupt, level

Behaviour:
- One clock HCLK. Reset is asynchronous on HRESETn low; all registers clear.
- Reset values: oData=0, outEn=0, irq=0, HRDATA=0, state IDLE, all registers 0.
- Bus protocol:
  - Address phase is valid when HSEL & HTRANS[1] & HREADY. HADDR[5:0] and the read/write flags are registered.
  - A write commits at the end of the following (data) cycle, using HWDATA.
  - HRDATA is combinational from the registered address and is valid in the data phase only; otherwise 0.
  - Zero wait states.
- Register map (byte offsets):
  - 0x00 CTRL:
    - bit0 START (write-1 pulse, reads 0)
    - bit1 STOP (write-1 pulse, reads 0)
    - bit2 LOOP
    - bit3 OEN_IDLE (outEn value while IDLE)
    - bit4 IRQ_EN
  - 0x04 STATUS:
    - bit0 BUSY (RO)
    - bit1 DONE (sticky; write 1 to clear)
    - bits[6:4] current step index (RO)
  - 0x08 LEN: bits[3:0], number of steps; values above DEPTH are clamped to DEPTH.
  - 0x0C IN: reads {24'b0, iData}; writes ignored.
  - 0x10 + 4*i PAT[i], i < DEPTH: bits[7:0] data, bits[8+HOLD_W-1:8] hold; read back as written.
  - Unmapped offsets read 0; writes to them are ignored.
- FSM states: IDLE, RUN.
- IDLE:
  - outEn = OEN_IDLE; oData holds its last value.
  - START commit with LEN≠0, at the same edge:
    - len_q <= LEN (LEN is sampled once; later LEN writes do not affect a run in progress)
    - idx <= 0
    - oData <= PAT[0].data
    - cnt <= PAT[0].hold
    - outEn <= 1
    - enter RUN
  - START with LEN=0: stay IDLE, set DONE.
- RUN:
  - outEn = 1, BUSY = 1.
  - cnt≠0: cnt decrements.
  - cnt=0 and idx<len_q-1: idx++, load the next entry's data and hold.
  - cnt=0 and idx=len_q-1:
    - LOOP=1: idx <= 0, reload PAT[0].
    - LOOP=0: set DONE, enter IDLE; oData keeps the last step value.
  - Each step is visible for hold+1 cycles (hold=0 gives 1 cycle).
- STOP commit in RUN: enter IDLE at that edge. DONE is not set; oData freezes.
- START and STOP in the same write: STOP wins. START while RUN is ignored.
- PAT writes during RUN are allowed and take effect the next time that entry is loaded. A write to the entry being loaded on that edge uses the old value.
- LOOP cleared during RUN: the sequence finishes at the end of the current pass.
- DONE set and a W1C clear in the same cycle: set wins.
- irq = DONE & IRQ_EN, registered.
- Reset mid-run: immediate return to reset values.

Test Plan:
- Reset → oData=0x00, outEn=0, irq=0. Reads of 0x00–0x2C all return 0 except IN, which returns iData (drive 0xA5 → read 0x000000A5).
- PAT0={0x11, hold 2}, PAT1={0x22, hold 0}, PAT2={0x33, hold 1}, LEN=3, START → oData shows 0x11 for 3 cycles, 0x22 for 1 cycle, 0x33 for 2 cycles, then IDLE. DONE=1, STATUS reads 0x00000022, oData stays 0x33.
- LOOP=1 with 2 steps → pattern repeats ≥3 passes. STOP mid-step → BUSY=0 on the next cycle, DONE=0, outEn=OEN_IDLE.
- LEN=0 with START → no oData change, DONE=1 immediately. With IRQ_EN=1, irq=1. W1C to STATUS bit1 → irq=0 one cycle later.
- Second START written during RUN, and a write of START|STOP → the first is ignored (sequence unchanged); the second stops the run.
- Write PAT1 during step 0 → the new PAT1 value appears at step 1. Deassert HRESETn mid-run → outputs go to reset values asynchronously.
